// File: rtl/array_server_pkg.sv
// array_server_pkg
// Shared constants for the array server slice. The data and address widths
// are taken from the common `intN / `addrN primitive constants; the guards
// only supply their standard values when no primitives header was compiled
// ahead of this file.
`ifndef intN
`define intN 32
`endif
`ifndef addrN
`define addrN 4
`endif

package array_server_pkg;

    localparam int INT_N  = `intN;
    localparam int ADDR_N = `addrN;

    // Depth of the read-response buffer; also the read occupancy limit.
    localparam int RESP_DEPTH = 2;

endpackage

// File: rtl/array_server_stream_skid2.sv
// stream_skid2
// Two-entry valid/ready FIFO. The output side is driven straight from the
// head register, so a pushed word appears one cycle after it was accepted.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o upstream stream (ready while not full)
//   out_data_o/out_valid_o/out_ready_i downstream stream
module stream_skid2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push_s, pop_s;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;

    // Next-state for the two entries and the fill count.
    always_comb begin
        push_s  = in_valid_i & in_ready_o;
        pop_s   = out_valid_o & out_ready_i;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        if (pop_s) begin
            // A full buffer never pushes, so popping it simply advances the tail.
            if (count_q == 2'd2) begin
                head_d = tail_q;
            end else if (push_s) begin
                head_d = in_data_i;
            end else begin
                head_d = head_q;
            end
        end else if (push_s) begin
            if (count_q == 2'd0) begin
                head_d = in_data_i;
            end else begin
                tail_d = in_data_i;
            end
        end else begin
            head_d = head_q;
        end
    end

    // Entry and count registers; reset empties the buffer and zeroes the output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/array_server.sv
// array_server
// N-entry register array served over valid/ready streams. Reads return
// {1, payload} for written entries and zero otherwise, with latency 1 and up
// to two responses in flight. Writes store DW-1 payload bits and complete with
// a one-bit acknowledge that must be consumed before the next write.
// Ports:
//   clk, rst                                  clock, async active-high reset
//   rd_addr/rd_addr_valid/rd_addr_ready       read requests
//   rd_data/rd_data_valid/rd_data_ready       read responses (in order)
//   wr_addr/wr_addr_valid/wr_addr_ready       write address
//   wr_data/wr_data_valid/wr_data_ready       write data (MSB ignored)
//   wr_ack_valid/wr_ack_ready                 write completion
module array_server
    import array_server_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = ADDR_N,
    parameter int DW = INT_N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_addr_valid,
    output logic          rd_addr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_valid,
    input  logic          rd_data_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_addr_valid,
    output logic          wr_addr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_data_valid,
    output logic          wr_data_ready,
    output logic          wr_ack_valid,
    input  logic          wr_ack_ready
);

    localparam logic [AW:0] N_LIM = (AW+1)'(N);

    logic [DW-2:0] mem_q [N];
    logic [N-1:0]  written_q, written_d;
    logic          ack_q, ack_d;
    logic          rd_in_range_s, wr_in_range_s;
    logic          rd_accept_s, wr_accept_s;
    logic          fifo_in_ready_s;
    logic [DW-1:0] rd_word_s;
    logic          wr_flag_unused_s;

    assign wr_flag_unused_s = wr_data[DW-1];

    assign rd_in_range_s = ({1'b0, rd_addr} < N_LIM);
    assign wr_in_range_s = ({1'b0, wr_addr} < N_LIM);

    // Occupancy is the buffer fill level, so "not full" is exactly occ < 2.
    assign rd_addr_ready = fifo_in_ready_s & ~rst;
    assign rd_accept_s   = rd_addr_valid & rd_addr_ready;

    // A pending ack only blocks a new write if it is not retired this cycle.
    assign wr_accept_s   = ~rst & wr_addr_valid & wr_data_valid & (~ack_q | wr_ack_ready);
    assign wr_addr_ready = wr_accept_s;
    assign wr_data_ready = wr_accept_s;
    assign wr_ack_valid  = ack_q;

    // Read lookup from current state, so a same-cycle write is not yet visible.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s && written_q[rd_addr]) begin
            rd_word_s = {1'b1, mem_q[rd_addr]};
        end else begin
            rd_word_s = '0;
        end
    end

    // Written-vector and acknowledge next state.
    always_comb begin
        written_d = written_q;
        ack_d     = ack_q;
        if (wr_accept_s && wr_in_range_s) begin
            written_d[wr_addr] = 1'b1;
        end else begin
            written_d = written_q;
        end
        if (wr_accept_s) begin
            ack_d = 1'b1;
        end else if (wr_ack_ready) begin
            ack_d = 1'b0;
        end else begin
            ack_d = ack_q;
        end
    end

    // Control state; reset forgets every entry and any outstanding ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            written_q <= written_d;
            ack_q     <= ack_d;
        end
    end

    // Payload storage; left unreset because written_q masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_accept_s && wr_in_range_s) begin
            mem_q[wr_addr] <= wr_data[DW-2:0];
        end
    end

    stream_skid2 #(
        .W (DW)
    ) u_resp_buf (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (rd_word_s),
        .in_valid_i  (rd_accept_s),
        .in_ready_o  (fifo_in_ready_s),
        .out_data_o  (rd_data),
        .out_valid_o (rd_data_valid),
        .out_ready_i (rd_data_ready)
    );

endmodule

// File: doc/array_server.md
ARRAY_SERVER -- requirements
Module: array_server

Interface
REQ-001 SHALL have parameter N, default 16, number of array entries.
REQ-002 SHALL have parameter AW, default `addrN (4), address width.
REQ-003 SHALL have parameter DW, default `intN (32), data width; bit DW-1 is the "entry valid" flag.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rd_addr / rd_addr_valid / rd_addr_ready  in / in / out  AW / 1 / 1  read-request stream.
REQ-007 SHALL have port rd_data / rd_data_valid / rd_data_ready  out / out / in  DW / 1 / 1  read-response stream.
REQ-008 SHALL have port wr_addr / wr_addr_valid / wr_addr_ready  in / in / out  AW / 1 / 1  write-address stream.
REQ-009 SHALL have port wr_data / wr_data_valid / wr_data_ready  in / in / out  DW / 1 / 1  write-data stream.
REQ-010 SHALL have port wr_ack_valid / wr_ack_ready  out / in  1 / 1  write-completion null stream.

Function
REQ-011 SHALL transfer on any stream only in a cycle where valid and ready are both high.
REQ-012 SHALL accept a write only when wr_addr_valid, wr_data_valid and no ack is pending (or the pending ack handshakes this cycle); wr_addr_ready and wr_data_ready SHALL be equal and asserted only then.
REQ-013 SHALL store wr_data[DW-2:0] at wr_addr, set written[wr_addr], ignore wr_data[DW-1].
REQ-014 SHALL raise wr_ack_valid the cycle after write acceptance and hold it until wr_ack_ready.
REQ-015 SHALL keep an occupancy counter occ (0..2) = read requests accepted minus responses handshaken; rd_addr_ready SHALL be (occ < 2).
REQ-016 SHALL present the response the cycle after request acceptance (latency 1) and sustain one read per cycle while rd_data_ready is high.
REQ-017 SHALL return rd_data = {1'b1, mem[a][DW-2:0]} if written[a], else all zeros.
REQ-018 SHALL keep responses in request order through a 2-entry buffer; rd_data and rd_data_valid held stable while valid and not ready.
REQ-019 Same-cycle read and write to the same address: read SHALL return pre-write contents (read-before-write).
REQ-020 Address >= N (when N < 2**AW): read SHALL return zero; write SHALL be dropped but still acknowledged.
REQ-021 Read and write paths SHALL be independent; a stalled rd_data_ready SHALL NOT block writes, a pending ack SHALL NOT block reads.

Reset
REQ-022 On rst: written[] all 0, occ 0, buffer empty, rd_data_valid 0, rd_data 0, wr_ack_valid 0, all ready outputs 0 while rst high.
REQ-023 mem contents SHALL NOT be reset; invisible since written[] is cleared.
REQ-024 Reset mid-operation SHALL discard in-flight responses and pending acks; first accepts possible in the first cycle after rst falls.

Structure
REQ-025 DW/AW defaults SHALL come from the shared `intN/`addrN constants in primitives; no local redefinition.
REQ-026 Response buffering SHALL be one sub-module, stream_skid2 (2-entry valid/ready FIFO, parameter width).
REQ-027 mem SHALL be an N x (DW-1) register array plus an N-bit written vector; no other storage.

Verification
REQ-028 After reset, read addr 5 -> rd_data = 0x00000000 one cycle later.
REQ-029 Write addr i data i+1 for i=0..15 with random valid gaps, then read 0..15 with random rd_data_ready -> 0x80000001..0x80000010 in order, 16 acks.
REQ-030 Hold rd_data_ready low, issue reads 3,4,5 -> only 2 accepted (rd_addr_ready falls at occ=2), rd_data stable; release -> 3,4,5 delivered in order.
REQ-031 Same cycle: write addr 7 data 0x99 and read addr 7 (prior 0x80000008) -> read returns 0x80000008; next read of 7 -> 0x80000099.
REQ-032 wr_ack_ready low with wr streams valid -> exactly one write accepted, ready low until ack consumed; reads still proceed.
REQ-033 Assert rst with occ=2 and ack pending -> rd_data_valid and wr_ack_valid drop immediately; subsequent read of any address returns 0.
